// File: rtl/bus_escritura_rtc.sv
// Write-cycle generator for the RTC multiplexed address/data bus.
// Latches address/data on request, runs address and data strobe phases, pulses fin, then holds off.
module bus_escritura_rtc #(
  parameter int unsigned T_PULSE = 8,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribe,
  input  logic [7:0] dir_in,
  input  logic [7:0] data_in,
  output logic [7:0] ad_bus,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       fin,
  output logic       ocupado
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADR   = 3'd1,
    ADR_H = 3'd2,
    DAT   = 3'd3,
    DAT_H = 3'd4,
    DONE  = 3'd5,
    GAP   = 3'd6
  } state_t;

  localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] HOLD_LD  = 8'(T_HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dato_q, dato_d;

  logic [7:0] ad_bus_q, ad_bus_d;
  logic       ad_oe_q, ad_oe_d;
  logic       a_d_q, a_d_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       fin_q, fin_d;
  logic       ocupado_q, ocupado_d;

  // Next state and counter; each state lasts (load value + 1) cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    dato_d  = dato_q;
    case (state_q)
      IDLE: begin
        if (escribe) begin
          dir_d   = dir_in;
          dato_d  = data_in;
          state_d = ADR;
          cnt_d   = PULSE_LD;
        end
      end
      ADR: begin
        if (cnt_q == '0) begin
          state_d = ADR_H;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ADR_H: begin
        if (cnt_q == '0) begin
          state_d = DAT;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DAT: begin
        if (cnt_q == '0) begin
          state_d = DAT_H;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DAT_H: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = GAP;
        cnt_d   = GAP_LD;
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the upcoming state so they are registered yet line up with it.
  always_comb begin
    ad_bus_d  = '0;
    ad_oe_d   = 1'b0;
    a_d_d     = 1'b1;
    cs_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    fin_d     = 1'b0;
    ocupado_d = 1'b0;
    case (state_d)
      ADR: begin
        ad_bus_d  = dir_d;
        ad_oe_d   = 1'b1;
        a_d_d     = 1'b0;
        cs_n_d    = 1'b0;
        wr_n_d    = 1'b0;
        ocupado_d = 1'b1;
      end
      ADR_H: begin
        ad_bus_d  = dir_d;
        ad_oe_d   = 1'b1;
        a_d_d     = 1'b0;
        ocupado_d = 1'b1;
      end
      DAT: begin
        ad_bus_d  = dato_d;
        ad_oe_d   = 1'b1;
        cs_n_d    = 1'b0;
        wr_n_d    = 1'b0;
        ocupado_d = 1'b1;
      end
      DAT_H: begin
        ad_bus_d  = dato_d;
        ad_oe_d   = 1'b1;
        ocupado_d = 1'b1;
      end
      DONE: begin
        fin_d     = 1'b1;
        ocupado_d = 1'b1;
      end
      GAP: begin
        ocupado_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= '0;
      dato_q    <= '0;
      ad_bus_q  <= '0;
      ad_oe_q   <= 1'b0;
      a_d_q     <= 1'b1;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      fin_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      dato_q    <= dato_d;
      ad_bus_q  <= ad_bus_d;
      ad_oe_q   <= ad_oe_d;
      a_d_q     <= a_d_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      fin_q     <= fin_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign ad_bus  = ad_bus_q;
  assign ad_oe   = ad_oe_q;
  assign a_d     = a_d_q;
  assign cs_n    = cs_n_q;
  assign wr_n    = wr_n_q;
  assign rd_n    = 1'b1;
  assign fin     = fin_q;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_bus_escritura_rtc.sv
// Bench for bus_escritura_rtc: per-cycle timing model, vector table, and a fin-driven scoreboard.
module tb_bus_escritura_rtc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       esc_a = 1'b0, esc_b = 1'b0;
  logic [7:0] dir_a = '0, dat_a = '0, dir_b = '0, dat_b = '0;

  logic [7:0] ad_bus_a, ad_bus_b;
  logic       ad_oe_a, a_d_a, cs_n_a, wr_n_a, rd_n_a, fin_a, ocupado_a;
  logic       ad_oe_b, a_d_b, cs_n_b, wr_n_b, rd_n_b, fin_b, ocupado_b;

  always #5 clk = ~clk;

  bus_escritura_rtc #(.T_PULSE(8), .T_HOLD(4), .GAP_CYC(4)) u_a (
    .clk(clk), .reset(reset), .escribe(esc_a), .dir_in(dir_a), .data_in(dat_a),
    .ad_bus(ad_bus_a), .ad_oe(ad_oe_a), .a_d(a_d_a), .cs_n(cs_n_a), .wr_n(wr_n_a),
    .rd_n(rd_n_a), .fin(fin_a), .ocupado(ocupado_a)
  );

  bus_escritura_rtc #(.T_PULSE(1), .T_HOLD(1), .GAP_CYC(3)) u_b (
    .clk(clk), .reset(reset), .escribe(esc_b), .dir_in(dir_b), .data_in(dat_b),
    .ad_bus(ad_bus_b), .ad_oe(ad_oe_b), .a_d(a_d_b), .cs_n(cs_n_b), .wr_n(wr_n_b),
    .rd_n(rd_n_b), .fin(fin_b), .ocupado(ocupado_b)
  );

  // {ad_bus, ad_oe, a_d, cs_n, wr_n, rd_n, fin, ocupado}
  logic [14:0] obs_a, obs_b;
  assign obs_a = {ad_bus_a, ad_oe_a, a_d_a, cs_n_a, wr_n_a, rd_n_a, fin_a, ocupado_a};
  assign obs_b = {ad_bus_b, ad_oe_b, a_d_b, cs_n_b, wr_n_b, rd_n_b, fin_b, ocupado_b};

  localparam logic [14:0] IDLE_O = {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  int errors = 0;
  int checks = 0;
  bit msel = 1'b0;
  logic [15:0] sbq[$];

  typedef struct {
    logic [7:0] dir;
    logic [7:0] dat;
    int         chg_k;
    logic [7:0] dir2;
    logic [7:0] dat2;
    logic [7:0] exp_a;
    logic [7:0] exp_d;
  } vec_t;

  function automatic logic [14:0] obs_f(bit sel);
    return sel ? obs_b : obs_a;
  endfunction

  function automatic logic [14:0] model(int k, logic [7:0] a, logic [7:0] d, int tp, int th, int g);
    if (k < tp)                return {a,     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    if (k < tp + th)           return {a,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    if (k < 2*tp + th)         return {d,     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    if (k < 2*(tp + th))       return {d,     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    if (k == 2*(tp + th))      return {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    if (k <= 2*(tp + th) + g)  return {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    return IDLE_O;
  endfunction

  task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic set_esc(input bit sel, input logic v);
    if (sel) esc_b = v; else esc_a = v;
  endtask

  task automatic set_in(input bit sel, input logic [7:0] a, input logic [7:0] d);
    if (sel) begin dir_b = a; dat_b = d; end
    else begin dir_a = a; dat_a = d; end
  endtask

  // Called just after a negedge; the latch happens at the next posedge (start of cycle 0).
  task automatic txn(input bit sel, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_a, input logic [7:0] exp_d,
                     input int chg_k, input logic [7:0] a2, input logic [7:0] d2,
                     input int drop_k);
    int tp, th, g, last;
    tp = sel ? 1 : 8;
    th = sel ? 1 : 4;
    g  = sel ? 3 : 4;
    last = 2*(tp + th) + g + 1;
    set_in(sel, a, d);
    set_esc(sel, 1'b1);
    sbq.push_back({exp_a, exp_d});
    @(posedge clk);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      chk($sformatf("u%0d %h/%h k=%0d", sel, exp_a, exp_d, k), obs_f(sel),
          model(k, exp_a, exp_d, tp, th, g));
      if (k == drop_k) set_esc(sel, 1'b0);
      if (k == chg_k) set_in(sel, a2, d2);
    end
  endtask

  // Scoreboard: capture the values present at each strobe fall, compare on fin.
  logic [7:0] cap_a = '0, cap_d = '0;
  logic       prev_wr = 1'b1;
  logic [14:0] mo;
  logic [15:0] exp_pair;
  always @(negedge clk) begin
    mo = obs_f(msel);
    if (!reset) begin
      prev_wr = 1'b1;
    end else begin
      if (!mo[3] && prev_wr) begin
        if (!mo[5]) cap_a = mo[14:7];
        else        cap_d = mo[14:7];
      end
      prev_wr = mo[3];
      if (mo[1]) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb unexpected fin got=%h/%h want=none", cap_a, cap_d);
        end else begin
          exp_pair = sbq.pop_front();
          if ({cap_a, cap_d} !== exp_pair) begin
            errors++;
            $display("FAIL sb bus cycle got=%h/%h want=%h/%h", cap_a, cap_d,
                     exp_pair[15:8], exp_pair[7:0]);
          end
        end
      end
    end
  end

  vec_t vecs[4];

  initial begin
    vecs[0] = '{dir: 8'h21, dat: 8'h45, chg_k: -1, dir2: 8'h00, dat2: 8'h00, exp_a: 8'h21, exp_d: 8'h45};
    vecs[1] = '{dir: 8'h5A, dat: 8'h12, chg_k: 3,  dir2: 8'h5A, dat2: 8'h99, exp_a: 8'h5A, exp_d: 8'h12};
    vecs[2] = '{dir: 8'h00, dat: 8'hFF, chg_k: 15, dir2: 8'h77, dat2: 8'h88, exp_a: 8'h00, exp_d: 8'hFF};
    vecs[3] = '{dir: 8'hFF, dat: 8'h00, chg_k: 20, dir2: 8'h11, dat2: 8'h22, exp_a: 8'hFF, exp_d: 8'h00};

    // Reset held while escribe toggles
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      esc_a = i[0];
      esc_b = ~i[0];
      set_in(0, 8'hAA, 8'h55);
      chk($sformatf("rst a %0d", i), obs_a, IDLE_O);
      chk($sformatf("rst b %0d", i), obs_b, IDLE_O);
    end
    esc_a = 1'b0;
    esc_b = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post rst idle %0d", i), obs_a, IDLE_O);
    end

    // Vector table: single writes with input changes mid-cycle
    msel = 1'b0;
    for (int v = 0; v < 4; v++)
      txn(0, vecs[v].dir, vecs[v].dat, vecs[v].exp_a, vecs[v].exp_d,
          vecs[v].chg_k, vecs[v].dir2, vecs[v].dat2, 0);

    // Sequencer pairing: escribe held, inputs switch to F0/F0 three cycles after fin
    txn(0, 8'h22, 8'h33, 8'h22, 8'h33, 27, 8'hF0, 8'hF0, -1);
    txn(0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, -1, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("pair idle %0d", i), obs_a, IDLE_O);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pair pending got=%0d want=0", sbq.size());
    end

    // Mid-transaction reset in cycle 14
    set_in(0, 8'h3C, 8'hC3);
    esc_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("mrst k=%0d", k), obs_a, model(k, 8'h3C, 8'hC3, 8, 4, 4));
      if (k == 0) esc_a = 1'b0;
    end
    #2 reset = 1'b0;
    #1 chk("mrst async", obs_a, IDLE_O);
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mrst held %0d", i), obs_a, IDLE_O);
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk($sformatf("mrst after %0d", i), obs_a, IDLE_O);
    end

    // Parameter corner: T_PULSE=1, T_HOLD=1, GAP_CYC=3 with a held repeat request
    msel = 1'b1;
    txn(1, 8'h6B, 8'hB6, 8'h6B, 8'hB6, -1, 8'h00, 8'h00, -1);
    txn(1, 8'h6B, 8'hB6, 8'h6B, 8'hB6, -1, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("corner idle %0d", i), obs_b, IDLE_O);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL corner pending got=%0d want=0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_escritura_rtc.md
# bus_escritura_rtc

Physical write-cycle generator for the RTC's multiplexed address/data bus. It sits directly downstream of the write sequencer. It accepts a register address and data byte while `escribe` is high, then drives two bus strobes: an address phase followed by a data phase, each followed by a hold. It answers with a one-cycle `fin` pulse and then enforces a hold-off gap so that stale sequencer outputs are never re-sampled.

## Interface
- `T_PULSE`, default 8: cycles `cs_n`/`wr_n` are held low per phase; legal range 1..255.
- `T_HOLD`, default 4: cycles after each strobe with `cs_n`/`wr_n` high and the bus still driven; legal range 1..255.
- `GAP_CYC`, default 4: cycles after `fin` during which `escribe` is ignored; legal range 3..255.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `escribe`  in  1  write request from the sequencer, level-sensitive.
- `dir_in`  in  8  RTC register address.
- `data_in`  in  8  byte to write.
- `ad_bus`  out  8  value driven onto the multiplexed bus.
- `ad_oe`  out  1  tristate enable for the bus pads; 1 = drive.
- `a_d`  out  1  phase select; 0 = address phase, 1 = data phase.
- `cs_n`  out  1  chip select, active-low.
- `wr_n`  out  1  write strobe, active-low.
- `rd_n`  out  1  read strobe; held at 1 by this block.
- `fin`  out  1  one-cycle completion pulse back to the sequencer.
- `ocupado`  out  1  high from latch through the end of the gap.

## Operation
- All outputs are registered.
- While `reset` is 0, outputs take their reset values immediately and asynchronously: `ad_bus`=0, `ad_oe`=0, `a_d`=1, `cs_n`=1, `wr_n`=1, `rd_n`=1, `fin`=0, `ocupado`=0. State goes to IDLE and the latched address/data and counter clear to 0.
- State machine: IDLE, ADR, ADR_H, DAT, DAT_H, DONE, GAP. An 8-bit down-counter times each state.
- IDLE
  - Outputs are at their reset values.
  - If `escribe`=1 at a rising edge, latch `dir_in`→dir_q and `data_in`→dato_q, then go to ADR.
- ADR (T_PULSE cycles): `ad_oe`=1, `ad_bus`=dir_q, `a_d`=0, `cs_n`=0, `wr_n`=0, `ocupado`=1.
- ADR_H (T_HOLD cycles): as ADR, but `cs_n`=1 and `wr_n`=1.
- DAT (T_PULSE cycles): `ad_bus`=dato_q, `a_d`=1, `cs_n`=0, `wr_n`=0.
- DAT_H (T_HOLD cycles): as DAT, but `cs_n`=1 and `wr_n`=1.
- DONE (1 cycle): `fin`=1, `ad_oe`=0, `ad_bus`=0, `a_d`=1, strobes high.
- GAP (GAP_CYC cycles): `fin`=0 and `ocupado`=1; `escribe` is not sampled. Then go to IDLE.
- Latched values:
  - Changes on `dir_in`/`data_in` after the latch edge have no effect on the cycle in progress.
  - A new transaction always re-latches fresh values.
- If `escribe` drops mid-transaction, the bus cycle still completes and `fin` still pulses; a truncated strobe is never produced.
- `cs_n` and `wr_n` are always equal to each other.
- `ad_bus` never changes while `wr_n`=0.
- `a_d` changes only while the strobes are high.

## Timing
- Cycle 0 is the first cycle after the latching edge. With default parameters:
  - ADR: cycles 0..7.
  - ADR_H: cycles 8..11.
  - DAT: cycles 12..19.
  - DAT_H: cycles 20..23.
  - `fin`: cycle 24.
  - GAP: cycles 25..28.
  - IDLE: from cycle 29; the earliest new latch is at the edge ending cycle 29.
- General case:
  - `fin` occurs in cycle 2·(T_PULSE+T_HOLD).
  - Request-to-request spacing is at least 2·(T_PULSE+T_HOLD)+GAP_CYC+2 cycles.
- The GAP_CYC minimum of 3 covers the sequencer's two-cycle lag: it keeps `escribe` and the old address during the cycles after `fin` before presenting the transfer command (F0/F2) or dropping `escribe`.
- Back-to-back requests: if `escribe` is held high continuously, a second transaction starts at the first IDLE edge after GAP.
- Reset asserted mid-cycle: strobes release in the same instant, `fin` is not produced, and the first rising edge after release sees IDLE.

## Test plan
- **Reset values:** hold `reset`=0 while toggling `escribe`. Then release `reset`. Check all outputs at their reset values throughout, and no transaction until `escribe` is sampled high in IDLE.
- **Single write:** `dir_in`=8'h21, `data_in`=8'h45, `escribe` pulsed high for 1 cycle (defaults). Check:
  - `ad_bus`=21 with `a_d`=0 in cycles 0..11, `cs_n`/`wr_n` low in cycles 0..7.
  - `ad_bus`=45 with `a_d`=1 in cycles 12..23, strobes low in cycles 12..19.
  - `fin`=1 only in cycle 24.
- **Sequencer pairing:** drive the address 8'h22 transaction, then change `dir_in`/`data_in` to 8'hF0/8'hF0 three cycles after `fin`, keeping `escribe`=1. Check:
  - exactly two bus cycles; the second carries F0/F0.
  - no cycle repeats 8'h22.
- **Input change mid-cycle:** change `data_in` from 8'h12 to 8'h99 during ADR. Check that the data phase still drives 8'h12.
- **Mid-transaction reset:** assert `reset`=0 in cycle 14 (DAT). Check:
  - `cs_n`/`wr_n`=1 and `ad_oe`=0 asynchronously.
  - no `fin`.
  - after release, IDLE with no further strobes until `escribe` is sampled high.
- **Parameter corner:** T_PULSE=1, T_HOLD=1, GAP_CYC=3 with a `escribe` pulse. Check:
  - `fin` in cycle 4.
  - ADR, ADR_H, DAT and DAT_H one cycle each.
  - a repeat request is accepted only after the 3-cycle gap.
